// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared constants and FSM encoding for the u32 divider
package divider_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/AdderCH32bit.sv
// rtl/AdderCH32bit.sv - 32-bit adder with carry in/out
// Ports: op1, op2 (32-bit operands), cin (carry in), sum (32-bit), cout (carry out).
module AdderCH32bit (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, op1} + {1'b0, op2} + {32'd0, cin};

endmodule

// File: rtl/divider_u32.sv
// rtl/divider_u32.sv - 32-bit unsigned restoring divider, one quotient bit per cycle
// Ports: clk, rst (sync, active-high); start, dividend, divisor (request);
//        busy (iterating), done (one-cycle result pulse);
//        quotient, remainder, div_by_zero (held until the next op's done).
module divider_u32
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    div_state_t       state_q, state_d;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] rem_q;   // partial remainder (always < divisor between steps)
    logic [WIDTH-1:0] dq_q;    // dividend bits shift out the top, quotient bits shift in below
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             no_borrow;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dq_next;
    logic             accept;

    assign shifted = {rem_q, dq_q[WIDTH-1]};

    // shifted - divisor as shifted + ~divisor + 1; carry-out means no borrow in the low 32 bits
    AdderCH32bit u_sub (
        .op1  (shifted[WIDTH-1:0]),
        .op2  (~dvs_q),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    // A set bit 32 means the shifted value exceeds any 32-bit divisor
    assign no_borrow = shifted[WIDTH] | carry;
    assign qbit      = no_borrow;
    assign rem_next  = no_borrow ? diff : shifted[WIDTH-1:0];
    assign dq_next   = {dq_q[WIDTH-2:0], qbit};

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                rem_q <= '0;
                dq_q  <= dividend;
                dvs_q <= divisor;
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + 5'd1;
                rem_q <= rem_next;
                dq_q  <= dq_next;
                // Results are published only on the last step so RUN never exposes partials
                if (cnt_q == LAST_ITER) begin
                    quotient    <= dq_next;
                    remainder   <= rem_next;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule
